san_cnt: RTL and testbench
==========================

// Module: san_cnt
// PURPOSE
//  Programmable periodic-interrupt counter inside an AXI4-Lite slave IP. The
//  AXI slave wrapper decodes write transactions and forwards a write strobe,
//  the write address and data. san_cnt holds a PERIOD and a CTRL register,
//  counts clock cycles, pulses EXT_IRQ once per PERIOD cycles and exposes an
//  8-bit event count (COUNT_SAN) for LEDs/status.
// PARAMETERS
//  C_S_AXI_DATA_WIDTH  32  width of S_AXI_WDATA and PERIOD register
//  C_S_AXI_ADDR_WIDTH  3   width of axi_awaddr (byte address)
//  COUNT_WIDTH         8   width of COUNT_SAN event counter
// PORTS
//  S_AXI_ACLK     in   1   clock; all logic on rising edge
//  S_AXI_ARESETN  in   1   reset; synchronous, active-high despite the name
//  slv_reg_wren   in   1   register write strobe; one write per cycle high
//  axi_awaddr     in   3   byte write address; bit 2 selects register
//  S_AXI_WDATA    in   32  write data
//  EXT_IRQ        out  1   registered one-cycle interrupt pulse per period
//  COUNT_SAN      out  8   registered count of IRQ events, wraps 255->0
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high.
//  Reset (sampled high at edge): PERIOD=0, CTRL.EN=1, tick=0, COUNT_SAN=0,
//   EXT_IRQ=0. Reset overrides a simultaneous write; reset mid-count aborts.
//  Register map (axi_awaddr[1:0] ignored, full-word writes, no strobes):
//   0x0 PERIOD[31:0]: interrupt period in clock cycles; 0 = counter stopped.
//   0x4 CTRL: bit0 EN (1 = count), bit1 CLR (write 1: COUNT_SAN<=0 and
//       tick<=0 at that edge; self-clearing, not stored). Other bits ignored.
//  Write takes effect at the edge where slv_reg_wren=1; new value used from
//   the next edge. Writing PERIOD does NOT restart tick (a strobe held high
//   rewriting the same value is harmless).
//  Internal tick counter, 32 bits. Each edge when EN=1 and PERIOD!=0:
//   if tick >= PERIOD-1: tick<=0, EXT_IRQ<=1, COUNT_SAN<=COUNT_SAN+1 (mod 256)
//   else: tick<=tick+1, EXT_IRQ<=0.
//  ">=" comparison: if PERIOD is lowered below tick, wrap on the next edge.
//  PERIOD=1: EXT_IRQ high every cycle, COUNT_SAN increments every cycle.
//  PERIOD=0 or EN=0: tick and COUNT_SAN hold, EXT_IRQ<=0.
//  CLR and a terminal count on the same edge: CLR wins, COUNT_SAN=0, no IRQ.
//  Latency: PERIOD=N written at edge E0 from tick=0 -> first EXT_IRQ high
//   for one cycle after edge E0+N, then every N cycles; COUNT_SAN updates at
//   the same edge as EXT_IRQ rises.
// TESTING
//  1 Reset high 1 cycle, no writes -> EXT_IRQ=0, COUNT_SAN=0 for 200 cycles.
//  2 Release reset, hold wren=1, addr=0, data=100 -> EXT_IRQ 1-cycle pulses
//    exactly 100 cycles apart, first 100 edges after first write edge;
//    COUNT_SAN=1,2,3 after pulses 1..3.
//  3 PERIOD=1 -> EXT_IRQ constant 1, COUNT_SAN 255->0 wrap after 256 cycles.
//  4 PERIOD=100, write CTRL=0 (EN=0) mid-count -> tick/COUNT_SAN frozen, no
//    IRQ; CTRL=1 -> resumes, next IRQ after remaining cycles.
//  5 Write CTRL=3 while COUNT_SAN=5 -> COUNT_SAN=0, tick=0 next cycle; write
//    PERIOD=10 while tick=50 -> IRQ on next edge.
//  6 Assert reset mid-period with wren=1 -> all outputs 0, PERIOD=0 at edge.

Source files
------------

// File: rtl/san_cnt.sv
// san_cnt: periodic-interrupt counter behind an AXI4-Lite slave wrapper.
// Holds a PERIOD and a CTRL register. It counts clock cycles and emits a
// one-cycle EXT_IRQ pulse every PERIOD cycles. COUNT_SAN counts the pulses.
module san_cnt #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 3,
    parameter int COUNT_WIDTH        = 8
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESETN,
    input  logic                          slv_reg_wren,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] axi_awaddr,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
    output logic                          EXT_IRQ,
    output logic [COUNT_WIDTH-1:0]        COUNT_SAN
);

    // The reset input is active-high even though its name suggests otherwise.
    logic reset;
    assign reset = S_AXI_ARESETN;

    logic [C_S_AXI_DATA_WIDTH-1:0] period;
    logic                          en;
    logic [C_S_AXI_DATA_WIDTH-1:0] tick;

    logic wr_period;
    logic wr_ctrl;
    logic clr;
    logic run;
    logic terminal;

    // The low address bits carry no meaning because only full-word accesses occur.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, axi_awaddr[1:0]};

    // Decode the register write. Compute the run and terminal-count conditions from the stored registers.
    always_comb begin
        wr_period = 1'b0;
        wr_ctrl   = 1'b0;
        clr       = 1'b0;
        run       = 1'b0;
        terminal  = 1'b0;
        if (slv_reg_wren) begin
            wr_period = ~axi_awaddr[2];
            wr_ctrl   = axi_awaddr[2];
        end
        clr      = wr_ctrl & S_AXI_WDATA[1];
        run      = en && (period != '0);
        terminal = tick >= (period - C_S_AXI_DATA_WIDTH'(1));
    end

    // Register file. A write becomes visible to the counter from the following edge.
    always_ff @(posedge S_AXI_ACLK) begin
        if (reset) begin
            period <= '0;
            en     <= 1'b1;
        end else begin
            if (wr_period) begin
                period <= S_AXI_WDATA;
            end
            if (wr_ctrl) begin
                en <= S_AXI_WDATA[0];
            end
        end
    end

    // Tick counter, interrupt pulse and event counter. CLR takes priority over a terminal count.
    always_ff @(posedge S_AXI_ACLK) begin
        if (reset) begin
            tick      <= '0;
            EXT_IRQ   <= 1'b0;
            COUNT_SAN <= '0;
        end else if (clr) begin
            tick      <= '0;
            EXT_IRQ   <= 1'b0;
            COUNT_SAN <= '0;
        end else if (run) begin
            if (terminal) begin
                tick      <= '0;
                EXT_IRQ   <= 1'b1;
                COUNT_SAN <= COUNT_SAN + COUNT_WIDTH'(1);
            end else begin
                tick    <= tick + C_S_AXI_DATA_WIDTH'(1);
                EXT_IRQ <= 1'b0;
            end
        end else begin
            EXT_IRQ <= 1'b0;
        end
    end

endmodule

// File: tb/tb_san_cnt.sv
// Testbench for san_cnt. A reference model pushes the expected {irq, count} for each driven cycle.
// A monitor pops and compares that entry after the clock edge. Directed checks cover the timing points.
module tb_san_cnt;

    logic        clk;
    logic        rst;
    logic        wren;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic        irq;
    logic [7:0]  count;

    int check_count = 0;
    int error_count = 0;

    logic [8:0] exp_q[$];

    // Reference model state
    logic [31:0] m_period;
    logic        m_en;
    logic [31:0] m_tick;
    logic        m_irq;
    logic [7:0]  m_count;

    san_cnt dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst),
        .slv_reg_wren  (wren),
        .axi_awaddr    (addr),
        .S_AXI_WDATA   (wdata),
        .EXT_IRQ       (irq),
        .COUNT_SAN     (count)
    );

    // Free-running clock with a 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs on the falling edge and advance the model.
    // Push the expected outputs, then wait until just after the rising edge.
    task automatic applyStimulus(input logic r, input logic w, input logic [2:0] a, input logic [31:0] d);
        logic clr_now;
        @(negedge clk);
        rst   = r;
        wren  = w;
        addr  = a;
        wdata = d;
        if (r) begin
            m_period = 0;
            m_en     = 1'b1;
            m_tick   = 0;
            m_irq    = 1'b0;
            m_count  = 0;
        end else begin
            clr_now = w && a[2] && d[1];
            if (clr_now) begin
                m_tick  = 0;
                m_count = 0;
                m_irq   = 1'b0;
            end else if (m_en && m_period != 0) begin
                if (m_tick + 1 >= m_period) begin
                    m_tick  = 0;
                    m_irq   = 1'b1;
                    m_count = m_count + 8'd1;
                end else begin
                    m_tick = m_tick + 1;
                    m_irq  = 1'b0;
                end
            end else begin
                m_irq = 1'b0;
            end
            if (w && !a[2]) m_period = d;
            if (w && a[2])  m_en = d[0];
        end
        exp_q.push_back({m_irq, m_count});
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 3'd0, 32'd0);
    endtask

    // Scoreboard monitor: compare each registered output against the queued expectation.
    initial begin
        logic [8:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checkOutput("sb_irq", {31'd0, irq}, {31'd0, e[8]});
                checkOutput("sb_count", {24'd0, count}, {24'd0, e[7:0]});
            end
        end
    end

    initial begin
        logic [7:0] c0;
        rst   = 1'b1;
        wren  = 1'b0;
        addr  = 3'd0;
        wdata = 32'd0;
        m_period = 0; m_en = 1'b1; m_tick = 0; m_irq = 1'b0; m_count = 0;

        // 1: a single reset cycle, then 200 idle cycles with nothing counting
        applyStimulus(1'b1, 1'b0, 3'd0, 32'd0);
        checkOutput("t1_reset_irq", {31'd0, irq}, 32'd0);
        checkOutput("t1_reset_count", {24'd0, count}, 32'd0);
        idle(200);
        checkOutput("t1_idle_count", {24'd0, count}, 32'd0);

        // 2: write strobe held on PERIOD=100; pulses after edges 101, 201 and 301
        for (int i = 1; i <= 301; i++) begin
            applyStimulus(1'b0, 1'b1, 3'd0, 32'd100);
            if (i > 1 && (i - 1) % 100 == 0) begin
                checkOutput("t2_irq", {31'd0, irq}, 32'd1);
                checkOutput("t2_count", {24'd0, count}, (i - 1) / 100);
            end
        end

        // 3: PERIOD=1 keeps IRQ high. COUNT_SAN returns to the same value after 256 cycles.
        applyStimulus(1'b0, 1'b1, 3'd0, 32'd1);
        idle(1);
        c0 = count;
        idle(256);
        checkOutput("t3_irq_const", {31'd0, irq}, 32'd1);
        checkOutput("t3_wrap", {24'd0, count}, {24'd0, c0});
        // CLR coincides with a terminal count. CLR wins.
        applyStimulus(1'b0, 1'b1, 3'd4, 32'd3);
        checkOutput("t3_clr_irq", {31'd0, irq}, 32'd0);
        checkOutput("t3_clr_count", {24'd0, count}, 32'd0);

        // 4: freeze with EN=0 mid-count, then resume. The next IRQ comes after the remaining cycles.
        applyStimulus(1'b1, 1'b0, 3'd0, 32'd0);
        applyStimulus(1'b0, 1'b1, 3'd0, 32'd100);
        idle(40);
        applyStimulus(1'b0, 1'b1, 3'd4, 32'd0);
        idle(50);
        checkOutput("t4_frozen_count", {24'd0, count}, 32'd0);
        applyStimulus(1'b0, 1'b1, 3'd4, 32'd1);
        idle(58);
        checkOutput("t4_no_early_irq", {31'd0, irq}, 32'd0);
        idle(1);
        checkOutput("t4_resume_irq", {31'd0, irq}, 32'd1);
        checkOutput("t4_resume_count", {24'd0, count}, 32'd1);

        // 5: CLR at COUNT_SAN=5. Lowering PERIOD below tick wraps on the next edge.
        applyStimulus(1'b1, 1'b0, 3'd0, 32'd0);
        applyStimulus(1'b0, 1'b1, 3'd0, 32'd2);
        idle(10);
        checkOutput("t5_count5", {24'd0, count}, 32'd5);
        applyStimulus(1'b0, 1'b1, 3'd4, 32'd3);
        checkOutput("t5_clr_count", {24'd0, count}, 32'd0);
        applyStimulus(1'b0, 1'b1, 3'd0, 32'd100);
        idle(49);
        applyStimulus(1'b0, 1'b1, 3'd0, 32'd10);
        checkOutput("t5_write_edge_irq", {31'd0, irq}, 32'd0);
        idle(1);
        checkOutput("t5_lower_irq", {31'd0, irq}, 32'd1);
        checkOutput("t5_lower_count", {24'd0, count}, 32'd1);

        // 6: reset mid-period with a simultaneous write. PERIOD ends up 0, so nothing counts afterwards.
        idle(4);
        applyStimulus(1'b1, 1'b1, 3'd0, 32'd55);
        checkOutput("t6_reset_irq", {31'd0, irq}, 32'd0);
        checkOutput("t6_reset_count", {24'd0, count}, 32'd0);
        idle(80);
        checkOutput("t6_after_count", {24'd0, count}, 32'd0);

        #10;
        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
